// File: rtl/cam_pixel_capture_pkg.sv
// Shared types and constants for the OV7670 pixel capture stage.
//   cap_state_t : capture controller states
//   pix_fmt_t   : output pixel format selection
//   PIX_DATA_W  : frame-buffer write data width
//   decode_fmt  : maps the raw 2-bit format input onto pix_fmt_t (reserved -> RGB444)
package cam_pkg;

    typedef enum logic [1:0] {
        WAIT_CFG = 2'd0,
        SKIP     = 2'd1,
        IDLE     = 2'd2,
        CAPTURE  = 2'd3
    } cap_state_t;

    typedef enum logic [1:0] {
        FMT_RGB444 = 2'd0,
        FMT_RGB565 = 2'd1,
        FMT_Y      = 2'd2
    } pix_fmt_t;

    localparam int PIX_DATA_W = 16;

    function automatic pix_fmt_t decode_fmt(input logic [1:0] fmt);
        pix_fmt_t f;
        case (fmt)
            2'd1:    f = FMT_RGB565;
            2'd2:    f = FMT_Y;
            default: f = FMT_RGB444;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/cam_pixel_capture_if.sv
// Frame-buffer write port.
//   o_pix_addr : write address
//   o_pix_data : write data (zero-extended in the MSBs)
//   o_wr       : one-cycle write strobe
// master = capture stage (drives), slave = frame buffer (receives).
interface cam_pixel_capture_if #(
    parameter int ADDR_W = 19
);
    logic [ADDR_W-1:0]              o_pix_addr;
    logic [cam_pkg::PIX_DATA_W-1:0] o_pix_data;
    logic                           o_wr;

    modport master (output o_pix_addr, output o_pix_data, output o_wr);
    modport slave  (input  o_pix_addr, input  o_pix_data, input  o_wr);
endinterface

// File: rtl/cam_pixel_capture_byte_pack.sv
// Byte pairing and format mux for the camera parallel bus.
//   i_pclk, i_rst_n : clock, async active-low reset
//   i_href          : active-byte qualifier
//   i_drop          : discard the current byte and restart on byte 0
//   i_D             : camera data byte
//   i_fmt           : latched pixel format
//   o_phase         : current byte phase (1 = byte 0 held, waiting for byte 1)
//   o_pix_valid     : byte 1 present this cycle, o_pix_data is a full pixel
//   o_pix_data      : assembled pixel (combinational)
module cam_byte_pack
    import cam_pkg::*;
(
    input  logic                  i_pclk,
    input  logic                  i_rst_n,
    input  logic                  i_href,
    input  logic                  i_drop,
    input  logic [7:0]            i_D,
    input  pix_fmt_t              i_fmt,
    output logic                  o_phase,
    output logic                  o_pix_valid,
    output logic [PIX_DATA_W-1:0] o_pix_data
);
    logic       r_phase;
    logic [7:0] r_byte0;

    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase <= 1'b0;
            r_byte0 <= 8'd0;
        end else if (!i_href || i_drop) begin
            // every line starts on byte 0; a dangling byte 0 is simply forgotten
            r_phase <= 1'b0;
        end else begin
            r_phase <= ~r_phase;
            if (!r_phase) begin
                r_byte0 <= i_D;
            end
        end
    end

    always_comb begin
        o_pix_data = '0;
        case (i_fmt)
            FMT_RGB565: o_pix_data = {r_byte0, i_D};
            FMT_Y:      o_pix_data = {8'd0, r_byte0};
            default:    o_pix_data = {4'd0, r_byte0[3:0], i_D};
        endcase
    end

    assign o_phase     = r_phase;
    assign o_pix_valid = i_href & r_phase & ~i_drop;
endmodule

// File: rtl/cam_pixel_capture.sv
// OV7670 pixel capture stage, pixel-clock domain, feeding a frame-buffer write port.
//   i_pclk, i_rst_n        : clock, async active-low reset
//   i_vsync, i_href, i_D   : camera parallel bus
//   i_cam_done             : camera register configuration complete
//   i_en                   : capture enable (sampled at frame start)
//   i_fmt, i_decim         : format / 2:1 decimation (latched at frame start)
//   fb                     : frame-buffer write port (master)
//   o_frame_done           : pulse at end of each captured frame
//   o_line_err/o_frame_err : geometry error pulses
//   o_frame_cnt            : captured frame counter (wraps)
//
// state    | meaning
// WAIT_CFG | camera not configured yet, waiting for first frame start after i_cam_done
// SKIP     | discarding start-up frames until SKIP_FRAMES frame ends have passed
// IDLE     | between frames, waiting for a frame start with i_en high
// CAPTURE  | writing the current frame to the frame buffer
module cam_pixel_capture
    import cam_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int ADDR_W      = 19,
    parameter int SKIP_FRAMES = 2,
    parameter int FCNT_W      = 8
) (
    input  logic                      i_pclk,
    input  logic                      i_rst_n,
    input  logic                      i_vsync,
    input  logic                      i_href,
    input  logic [7:0]                i_D,
    input  logic                      i_cam_done,
    input  logic                      i_en,
    input  logic [1:0]                i_fmt,
    input  logic                      i_decim,
    cam_pixel_capture_if.master       fb,
    output logic                      o_frame_done,
    output logic                      o_line_err,
    output logic                      o_frame_err,
    output logic [FCNT_W-1:0]         o_frame_cnt
);
    localparam int COL_W     = $clog2(H_ACTIVE + 2);
    localparam int LINE_W    = $clog2(V_ACTIVE + 2);
    localparam int SKIP_W    = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES) : 1;
    localparam int SKIP_LAST = (SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0;

    cap_state_t        r_state, w_state_nxt;
    logic              r_vsync_d, r_href_d;
    logic [SKIP_W-1:0] r_skip_cnt;
    logic [COL_W-1:0]  r_col;
    logic [LINE_W-1:0] r_line;
    logic [ADDR_W-1:0] r_addr;
    pix_fmt_t          r_fmt;
    logic              r_decim;

    logic                  w_frame_start, w_frame_end, w_href_fall;
    logic                  w_start_cap, w_end_cap, w_wr_ok;
    logic                  w_phase, w_pix_valid;
    logic [PIX_DATA_W-1:0] w_pix_data;

    assign w_frame_start = r_vsync_d & ~i_vsync;
    assign w_frame_end   = ~r_vsync_d & i_vsync;
    assign w_href_fall   = r_href_d & ~i_href;

    cam_byte_pack u_byte_pack (
        .i_pclk      (i_pclk),
        .i_rst_n     (i_rst_n),
        .i_href      (i_href),
        .i_drop      (w_frame_start),
        .i_D         (i_D),
        .i_fmt       (r_fmt),
        .o_phase     (w_phase),
        .o_pix_valid (w_pix_valid),
        .o_pix_data  (w_pix_data)
    );

    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= WAIT_CFG;
            r_vsync_d  <= 1'b0;
            r_href_d   <= 1'b0;
            r_skip_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_vsync_d <= i_vsync;
            r_href_d  <= i_href;
            if (r_state == SKIP && w_frame_end) begin
                r_skip_cnt <= r_skip_cnt + 1'b1;
            end else if (r_state != SKIP) begin
                r_skip_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_cap = 1'b0;
        w_end_cap   = 1'b0;
        case (r_state)
            WAIT_CFG: if (w_frame_start && i_cam_done) begin
                w_state_nxt = (SKIP_FRAMES == 0) ? IDLE : SKIP;
            end
            SKIP: if (w_frame_end && r_skip_cnt == SKIP_W'(SKIP_LAST)) begin
                w_state_nxt = IDLE;
            end
            IDLE: if (w_frame_start && i_en) begin
                w_state_nxt = CAPTURE;
                w_start_cap = 1'b1;
            end
            CAPTURE: if (w_frame_end) begin
                w_state_nxt = IDLE;
                w_end_cap   = 1'b1;
            end
            default: w_state_nxt = WAIT_CFG;
        endcase
    end

    // decimation keeps only even columns of even lines
    assign w_wr_ok = w_pix_valid
                   && (r_col < COL_W'(H_ACTIVE))
                   && (r_line < LINE_W'(V_ACTIVE))
                   && (!r_decim || (!r_col[0] && !r_line[0]));

    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_col         <= '0;
            r_line        <= '0;
            r_addr        <= '0;
            r_fmt         <= FMT_RGB444;
            r_decim       <= 1'b0;
            fb.o_pix_addr <= '0;
            fb.o_pix_data <= '0;
            fb.o_wr       <= 1'b0;
            o_frame_done  <= 1'b0;
            o_line_err    <= 1'b0;
            o_frame_err   <= 1'b0;
            o_frame_cnt   <= '0;
        end else begin
            fb.o_wr      <= 1'b0;
            o_frame_done <= 1'b0;
            o_line_err   <= 1'b0;
            o_frame_err  <= 1'b0;
            if (w_start_cap) begin
                r_col   <= '0;
                r_line  <= '0;
                r_addr  <= '0;
                r_fmt   <= decode_fmt(i_fmt);
                r_decim <= i_decim;
            end else if (r_state == CAPTURE) begin
                if (w_pix_valid && r_col != COL_W'(H_ACTIVE + 1)) begin
                    r_col <= r_col + 1'b1;
                end
                if (w_wr_ok) begin
                    fb.o_wr       <= 1'b1;
                    fb.o_pix_addr <= r_addr;
                    fb.o_pix_data <= w_pix_data;
                    r_addr        <= r_addr + 1'b1;
                end
                if (w_href_fall) begin
                    r_col <= '0;
                    if (r_line != LINE_W'(V_ACTIVE + 1)) begin
                        r_line <= r_line + 1'b1;
                    end
                    if (r_col != COL_W'(H_ACTIVE) || w_phase) begin
                        o_line_err <= 1'b1;
                    end
                end
                if (w_end_cap) begin
                    o_frame_done <= 1'b1;
                    o_frame_cnt  <= o_frame_cnt + 1'b1;
                    if (r_line != LINE_W'(V_ACTIVE)) begin
                        o_frame_err <= 1'b1;
                    end
                end
            end
        end
    end
endmodule
